// File: rtl/flash_arb_pkg.sv
// Shared definitions for the Flash access arbiter: state encoding,
// direction codes, default timing and the latched transaction layout.
package flash_arb_pkg;

    // Sequencer states (legacy-compatible constant encoding)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Flash direction codes
    localparam logic FL_DIR_READ  = 1'b0;
    localparam logic FL_DIR_WRITE = 1'b1;

    // 1_000_000 cycles is 20 ms at 50 MHz; the counter must reach TIMEOUT_CYCLES-1
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;
    localparam int DEFAULT_CNT_W          = 20;

    // One requester's Flash transaction as captured at grant time
    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } flash_txn_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational winner select plus a
// registered priority pointer that moves past the requester just served.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant_done,
    input  logic i_granted,
    output logic o_valid,
    output logic o_winner
);

    logic r_ptr;

    assign o_valid = i_req0 | i_req1;

    // Winner: a lone requester always wins; on contention the pointer decides
    always_comb begin
        // NOTE: o_winner gets a value before any branch so no latch is inferred.
        o_winner = i_req1;
        if (i_req0 && i_req1) begin
            o_winner = r_ptr;
        end
    end

    // Pointer favours the requester that was not served by the completed grant
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_grant_done) begin
            r_ptr <= ~i_granted;
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Shares one Flash byte port between the UART command path (requester 0)
// and the scoreboard display refresh reader (requester 1). One access per
// grant: latch the winner, pulse fl_start, wait for fl_done or a timeout,
// then return data/error to the winner with a one-cycle ack.
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       req0,
    input  logic       rw0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    output logic       err0,
    input  logic       req1,
    input  logic       rw1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       err1,
    output logic       fl_start,
    output logic       fl_dir,
    output logic [7:0] fl_addr,
    output logic [7:0] fl_wdata,
    input  logic [7:0] fl_rdata,
    input  logic       fl_done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_grant;
    flash_txn_t       r_txn;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_rdata;
    logic             r_err;

    logic             w_req_any;
    logic             w_winner;
    logic             w_active;
    logic             w_resp;
    flash_txn_t       w_txn0;
    flash_txn_t       w_txn1;

    assign w_txn0   = '{rw: rw0, addr: addr0, wdata: wdata0};
    assign w_txn1   = '{rw: rw1, addr: addr1, wdata: wdata1};
    assign w_active = (r_state != IDLE);
    assign w_resp   = (r_state == RESP);

    // Pointer advances when the response is handed back, i.e. once per grant
    rr_arb2 u_rr_arb2 (
        .clk          (CLK_50MHZ),
        .rst          (RST),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_grant_done (w_resp),
        .i_granted    (r_grant),
        .o_valid      (w_req_any),
        .o_winner     (w_winner)
    );

    // Access sequencer: grant/latch in IDLE, start pulse, bounded wait, response
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_txn   <= '0;
            r_cnt   <= '0;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_grant <= w_winner;
                        r_txn   <= w_winner ? w_txn1 : w_txn0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // fl_done seen here belongs to no access of ours
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (fl_done) begin
                        // Done wins over a coincident terminal count; writes capture too
                        r_rdata <= fl_rdata;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= 8'h00;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Flash port is driven from the latch from ISSUE through RESP, zero in IDLE
    assign fl_start = (r_state == ISSUE);
    assign fl_dir   = w_active ? r_txn.rw    : FL_DIR_READ;
    assign fl_addr  = w_active ? r_txn.addr  : 8'h00;
    assign fl_wdata = w_active ? r_txn.wdata : 8'h00;
    assign busy     = w_active;

    // Response goes only to the granted requester; data/error are zero otherwise
    assign ack0   = w_resp & ~r_grant;
    assign ack1   = w_resp &  r_grant;
    assign rdata0 = ack0 ? r_rdata : 8'h00;
    assign rdata1 = ack1 ? r_rdata : 8'h00;
    assign err0   = ack0 & r_err;
    assign err1   = ack1 & r_err;

endmodule
